// File: rtl/la_netkeeper_pkg.sv
// la_netkeeper_pkg
// Shared definitions for the la_netkeeper net keeper cell:
//   - chan_state_t : per-channel keeper state (idle / drive / hold)
//   - cntw()       : width of the hold-window down counter for a given
//                    hold length (never narrower than one bit)
// The state literals carry an ST_ prefix so they cannot collide with the
// HOLD parameter of the modules that import this package.
package la_netkeeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_HOLD  = 2'b10
  } chan_state_t;

  // A hold of 0 means "hold forever", so the counter is unused,
  // but a one-bit minimum width keeps the declarations legal.
  function automatic int cntw(input int hold);
    return (hold <= 0) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/la_netkeeper_chan.sv
// la_netkeeper_chan
// One keeper channel: follows its driver while driven, freezes the last
// value for HOLD cycles once released, then clamps the net to vss.
// A global discharge request overrides everything except reset.
//
// Optional feature macro: LA_NETKEEPER_EXPIRE_EN adds the expired pulse.
//
// Ports:
//   clk     in  rising-edge clock
//   nreset  in  asynchronous active-low reset
//   vss     in  ground reference used as the clamp value
//   drive   in  driver-active qualifier
//   d       in  driver data
//   req     in  global discharge request
//   z       out kept net (registered)
//   held    out channel is in hold
//   idle    out channel is idle (feeds the shared acknowledge)
//   expired out one-cycle pulse on timeout discharge (macro only)
module la_netkeeper_chan #(
  parameter int HOLD = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic vss,
  input  logic drive,
  input  logic d,
  input  logic req,
  output logic z,
  output logic held,
`ifdef LA_NETKEEPER_EXPIRE_EN
  output logic idle,
  output logic expired
`else
  output logic idle
`endif
);

  import la_netkeeper_pkg::*;

  localparam int             CW    = cntw(HOLD);
  localparam bit             TIMED = (HOLD != 0);
  localparam logic [CW-1:0]  LOAD  = (HOLD == 0) ? '0 : CW'(HOLD - 1);

  chan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          z_nxt;
`ifdef LA_NETKEEPER_EXPIRE_EN
  logic          exp_nxt;
`endif

  // State, counter and net register; reset drops everything immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      z     <= 1'b0;
`ifdef LA_NETKEEPER_EXPIRE_EN
      expired <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      z     <= z_nxt;
`ifdef LA_NETKEEPER_EXPIRE_EN
      expired <= exp_nxt;
`endif
    end
  end

  // Next-state logic. Discharge wins over drive, drive wins over the
  // timeout, so re-driving in the timeout cycle skips the discharge.
  // Entering DRIVE from IDLE does not load z; data appears one edge later.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    z_nxt     = z;
`ifdef LA_NETKEEPER_EXPIRE_EN
    exp_nxt   = 1'b0;
`endif
    if (req) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      z_nxt     = vss;
    end else begin
      case (state)
        ST_IDLE: begin
          z_nxt = vss;
          if (drive) state_nxt = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (drive) begin
            z_nxt = d;
          end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = LOAD;
          end
        end
        ST_HOLD: begin
          if (drive) begin
            state_nxt = ST_DRIVE;
            z_nxt     = d;
          end else if (TIMED && (cnt == '0)) begin
            state_nxt = ST_IDLE;
            z_nxt     = vss;
`ifdef LA_NETKEEPER_EXPIRE_EN
            exp_nxt   = 1'b1;
`endif
          end else if (TIMED) begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          z_nxt     = vss;
        end
      endcase
    end
  end

  assign held = (state == ST_HOLD);
  assign idle = (state == ST_IDLE);

endmodule

// File: rtl/la_netkeeper.sv
// la_netkeeper
// Multi-channel net keeper / discharge cell. Each of N nets follows its
// driver, holds its last value for HOLD cycles after release (HOLD=0:
// forever), then clamps to vss. A four-phase discharge_req/discharge_ack
// handshake forces all channels idle.
//
// Optional feature macro: LA_NETKEEPER_EXPIRE_EN adds port expired[N-1:0].
//
// Ports:
//   clk            in  rising-edge clock
//   nreset         in  asynchronous active-low reset
//   vss            in  ground reference (clamp value)
//   drive[N-1:0]   in  per-channel driver-active qualifier
//   d[N-1:0]       in  per-channel driver data
//   discharge_req  in  global force-discharge request
//   discharge_ack  out global discharge acknowledge
//   z[N-1:0]       out kept nets, registered
//   held[N-1:0]    out channel is holding
//   expired[N-1:0] out timeout-discharge pulse (macro only)
module la_netkeeper #(
  parameter int N    = 8,
  parameter int HOLD = 16,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         vss,
  input  logic [N-1:0] drive,
  input  logic [N-1:0] d,
  input  logic         discharge_req,
  output logic         discharge_ack,
  output logic [N-1:0] z,
`ifdef LA_NETKEEPER_EXPIRE_EN
  output logic [N-1:0] held,
  output logic [N-1:0] expired
`else
  output logic [N-1:0] held
`endif
);

  logic [N-1:0] idle;
  logic         req_seen;

  for (genvar i = 0; i < N; i++) begin : g_chan
    la_netkeeper_chan #(
      .HOLD (HOLD)
    ) u_chan (
      .clk     (clk),
      .nreset  (nreset),
      .vss     (vss),
      .drive   (drive[i]),
      .d       (d[i]),
      .req     (discharge_req),
      .z       (z[i]),
      .held    (held[i]),
`ifdef LA_NETKEEPER_EXPIRE_EN
      .idle    (idle[i]),
      .expired (expired[i])
`else
      .idle    (idle[i])
`endif
    );
  end

  // The acknowledge needs the request seen on the previous edge as well,
  // so it always lands two edges after the request rises: the first edge
  // idles every channel, the second confirms they are all idle. Dropping
  // the request clears both flops on the next edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      req_seen      <= 1'b0;
      discharge_ack <= 1'b0;
    end else begin
      req_seen      <= discharge_req;
      discharge_ack <= discharge_req & req_seen & (&idle);
    end
  end

endmodule

// File: tb/tb_la_netkeeper.sv
// tb_la_netkeeper
// Directed bench for la_netkeeper. Three instances share the same inputs
// with HOLD=16, HOLD=4 and HOLD=0; each scenario only inspects the
// instance it targets. Define LA_NETKEEPER_EXPIRE_EN to also check expired.
module tb_la_netkeeper;

  localparam int N = 8;

  logic         clk;
  logic         nreset;
  logic         vss;
  logic [N-1:0] drive;
  logic [N-1:0] d;
  logic         req;

  logic         ack16, ack4, ack0;
  logic [N-1:0] z16, z4, z0;
  logic [N-1:0] held16, held4, held0;
`ifdef LA_NETKEEPER_EXPIRE_EN
  logic [N-1:0] exp16, exp4, exp0;
`endif

  int total;
  int bad;

  la_netkeeper #(.N(N), .HOLD(16), .PROP("DEFAULT")) dut16 (
    .clk(clk), .nreset(nreset), .vss(vss), .drive(drive), .d(d),
    .discharge_req(req), .discharge_ack(ack16), .z(z16),
`ifdef LA_NETKEEPER_EXPIRE_EN
    .held(held16), .expired(exp16)
`else
    .held(held16)
`endif
  );

  la_netkeeper #(.N(N), .HOLD(4), .PROP("DEFAULT")) dut4 (
    .clk(clk), .nreset(nreset), .vss(vss), .drive(drive), .d(d),
    .discharge_req(req), .discharge_ack(ack4), .z(z4),
`ifdef LA_NETKEEPER_EXPIRE_EN
    .held(held4), .expired(exp4)
`else
    .held(held4)
`endif
  );

  la_netkeeper #(.N(N), .HOLD(0), .PROP("DEFAULT")) dut0 (
    .clk(clk), .nreset(nreset), .vss(vss), .drive(drive), .d(d),
    .discharge_req(req), .discharge_ack(ack0), .z(z0),
`ifdef LA_NETKEEPER_EXPIRE_EN
    .held(held0), .expired(exp0)
`else
    .held(held0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs and let exactly one rising edge consume them;
  // returns 1 time unit after that edge so outputs are settled.
  task automatic applyStimulus(input logic [N-1:0] drv, input logic [N-1:0] dd,
                               input logic rq);
    drive = drv;
    d     = dd;
    req   = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset pulse away from the clock edge, released after a tick.
  task automatic pulseReset();
    nreset = 1'b0;
    drive  = '0;
    d      = '0;
    req    = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    vss    = 1'b0;
    nreset = 1'b0;
    drive  = 8'hFF;
    d      = 8'hA5;
    req    = 1'b0;

    // Reset with drivers active: outputs stay at reset values.
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_z",    z16,    64'h00);
    checkOutput("rst_held", held16, 64'h00);
    checkOutput("rst_ack",  ack16,  64'h0);

    // Release: first edge enters DRIVE with z=0, second edge loads d.
    nreset = 1'b1;
    applyStimulus(8'hFF, 8'hA5, 1'b0);
    checkOutput("rel_edge1_z", z16, 64'h00);
    applyStimulus(8'hFF, 8'hA5, 1'b0);
    checkOutput("rel_edge2_z", z16, 64'hA5);
    checkOutput("rel_edge2_held", held16, 64'h00);

    // HOLD=16 timeout on ch0.
    pulseReset();
    applyStimulus(8'h01, 8'h01, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    checkOutput("t16_drive_z", z16, 64'h01);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput($sformatf("t16_hold%0d_held", i), held16, 64'h01);
      checkOutput($sformatf("t16_hold%0d_z", i),    z16,    64'h01);
`ifdef LA_NETKEEPER_EXPIRE_EN
      checkOutput($sformatf("t16_hold%0d_exp", i),  exp16,  64'h00);
`endif
    end
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("t16_c17_z",    z16,    64'h00);
    checkOutput("t16_c17_held", held16, 64'h00);
`ifdef LA_NETKEEPER_EXPIRE_EN
    checkOutput("t16_c17_exp",  exp16,  64'h01);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("t16_c18_exp",  exp16,  64'h00);
`endif

    // HOLD=4: re-drive ch3 on the exact timeout edge.
    pulseReset();
    applyStimulus(8'h08, 8'h08, 1'b0);
    applyStimulus(8'h08, 8'h08, 1'b0);
    checkOutput("t4_drive_z", z4, 64'h08);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("t4_cnt0_held", held4, 64'h08);
    checkOutput("t4_cnt0_z",    z4,    64'h08);
    applyStimulus(8'h08, 8'h08, 1'b0);
    checkOutput("t4_redrive_z",    z4,    64'h08);
    checkOutput("t4_redrive_held", held4, 64'h00);
`ifdef LA_NETKEEPER_EXPIRE_EN
    checkOutput("t4_redrive_exp",  exp4,  64'h00);
`endif
    applyStimulus(8'h08, 8'h00, 1'b0);
    checkOutput("t4_track_z", z4, 64'h00);

    // Forced discharge while all channels hold 5A.
    pulseReset();
    applyStimulus(8'hFF, 8'h5A, 1'b0);
    applyStimulus(8'hFF, 8'h5A, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("dis_hold_z",    z16,    64'h5A);
    checkOutput("dis_hold_held", held16, 64'hFF);
    applyStimulus(8'h00, 8'h00, 1'b1);
    checkOutput("dis_e1_z",    z16,    64'h00);
    checkOutput("dis_e1_held", held16, 64'h00);
    checkOutput("dis_e1_ack",  ack16,  64'h0);
`ifdef LA_NETKEEPER_EXPIRE_EN
    checkOutput("dis_e1_exp",  exp16,  64'h00);
`endif
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    checkOutput("dis_e2_ack", ack16, 64'h1);
    checkOutput("dis_e2_z",   z16,   64'h00);
    applyStimulus(8'h00, 8'h00, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    checkOutput("dis_e4_ack", ack16, 64'h1);
    checkOutput("dis_e4_z",   z16,   64'h00);
    applyStimulus(8'hFF, 8'hC3, 1'b0);
    checkOutput("dis_drop_ack", ack16, 64'h0);
    checkOutput("dis_drop_z",   z16,   64'h00);
    applyStimulus(8'hFF, 8'hC3, 1'b0);
    checkOutput("dis_resume_z", z16, 64'hC3);

    // HOLD=0: ch7 holds indefinitely until discharged.
    pulseReset();
    applyStimulus(8'h80, 8'h80, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 8'h00, 1'b0);
    end
    checkOutput("h0_1000_z",    z0,    64'h80);
    checkOutput("h0_1000_held", held0, 64'h80);
    applyStimulus(8'h00, 8'h00, 1'b1);
    checkOutput("h0_dis_z",    z0,    64'h00);
    checkOutput("h0_dis_held", held0, 64'h00);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Reset mid-hold: counter loaded to 15 then 10 decrements leaves 5.
    pulseReset();
    applyStimulus(8'h01, 8'h01, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(8'h00, 8'h00, 1'b0);
    end
    checkOutput("rsth_pre_held", held16, 64'h01);
    nreset = 1'b0;
    #1;
    checkOutput("rsth_z",    z16,    64'h00);
    checkOutput("rsth_held", held16, 64'h00);
    @(posedge clk); #1;
    nreset = 1'b1;

    // Reset while acknowledged; no ack survives.
    applyStimulus(8'h00, 8'h00, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b1);
    checkOutput("rsta_pre_ack", ack16, 64'h1);
    nreset = 1'b0;
    #1;
    checkOutput("rsta_ack", ack16, 64'h0);
    req = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("rsta_after_ack", ack16, 64'h0);
    checkOutput("rsta_after_z",   z16,   64'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
